// File: rtl/sys_defs.sv
// Shared definitions for the processor-memory bus arbiter: bus commands,
// memory tag/data sizing, arbitration owner and FSM state encodings.
// Pure declarations; no logic, no latency, no flow control.
package sys_defs;

   localparam int NUM_MEM_TAGS = 15;
   localparam int TAG_W        = $clog2(NUM_MEM_TAGS + 1);
   localparam int DATA_SIZE    = 64;
   localparam int STARVE_LIMIT = 4;
   localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      OWN_DCACHE = 1'b0,
      OWN_ICACHE = 1'b1
   } ARB_OWNER;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'h0,
      ARB_HOLD_D = 2'h1,
      ARB_HOLD_I = 2'h2
   } ARB_STATE;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tracks which requester owns each outstanding load tag; flags protocol errors.
// Latency: lookup is combinational (0 cycles); allocate/free land on the next clock.
// Backpressure: none; every allocate and return is absorbed in the cycle it arrives.
module mem_tag_owner_table
   import sys_defs::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_alloc_en,
   input  logic [TAG_W-1:0] i_alloc_tag,
   input  ARB_OWNER         i_alloc_owner,
   input  logic             i_ret_en,
   input  logic [TAG_W-1:0] i_ret_tag,
   output logic             o_ret_hit,
   output ARB_OWNER         o_ret_owner,
   input  logic             i_ext_err,
   output logic             o_err
);

   // Entry 0 stands for "no tag" and is never written, so it stays invalid.
   logic [NUM_MEM_TAGS:0] r_vld;
   logic [NUM_MEM_TAGS:0] r_own;
   logic                  r_err;

   logic w_free_same;
   logic w_collide;
   logic w_bad_ret;

   assign o_ret_hit   = i_ret_en && r_vld[i_ret_tag];
   assign o_ret_owner = ARB_OWNER'(r_own[i_ret_tag]);
   assign o_err       = r_err;

   // A tag being returned this cycle may be re-allocated without it counting as a collision.
   assign w_free_same = o_ret_hit && (i_ret_tag == i_alloc_tag);
   assign w_collide   = i_alloc_en && r_vld[i_alloc_tag] && !w_free_same;
   assign w_bad_ret   = i_ret_en && !r_vld[i_ret_tag];

   // Table update: allocation takes precedence over a same-cycle free of the same tag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_vld <= '0;
         r_own <= '0;
         r_err <= 1'b0;
      end else begin
         for (int i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (i_alloc_en && (i_alloc_tag == TAG_W'(i))) begin
               r_vld[i] <= 1'b1;
               r_own[i] <= i_alloc_owner;
            end else if (o_ret_hit && (i_ret_tag == TAG_W'(i))) begin
               r_vld[i] <= 1'b0;
            end
         end
         if (w_collide || w_bad_ret || i_ext_err) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between dcache and icache; routes acks and load returns to owners.
// Latency: grant, ack and return routing are combinational (0 cycles); state updates on clock.
// Backpressure: a zero memory ack holds the grant on the same requester until it is accepted.
module mem_bus_arbiter
   import sys_defs::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  BUS_COMMAND           dcache2mem_command,
   input  logic [31:0]          dcache2mem_addr,
   input  logic [DATA_SIZE-1:0] dcache2mem_data,
   output logic [TAG_W-1:0]     mem2dcache_response,
   output logic [TAG_W-1:0]     mem2dcache_tag,
   output logic [DATA_SIZE-1:0] mem2dcache_data,
   input  BUS_COMMAND           icache2mem_command,
   input  logic [31:0]          icache2mem_addr,
   output logic [TAG_W-1:0]     mem2icache_response,
   output logic [TAG_W-1:0]     mem2icache_tag,
   output logic [DATA_SIZE-1:0] mem2icache_data,
   output BUS_COMMAND           proc2mem_command,
   output logic [31:0]          proc2mem_addr,
   output logic [DATA_SIZE-1:0] proc2mem_data,
   input  logic [TAG_W-1:0]     mem2proc_response,
   input  logic [TAG_W-1:0]     mem2proc_tag,
   input  logic [DATA_SIZE-1:0] mem2proc_data,
   output logic                 err_tag
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   ARB_STATE            r_state;
   logic [STARVE_W-1:0] r_starve;

   logic     w_d_vld;
   logic     w_i_vld;
   logic     w_i_bad;
   logic     w_starved;
   logic     w_gnt_d;
   logic     w_gnt_i;
   logic     w_gnt;
   logic     w_accepted;
   logic     w_alloc_en;
   ARB_OWNER w_alloc_owner;
   logic     w_ret_en;
   logic     w_ret_hit;
   ARB_OWNER w_ret_owner;

   // Everything is qualified with !reset so the bus is quiet while reset is held.
   assign w_d_vld   = !reset && (dcache2mem_command != BUS_NONE);
   assign w_i_vld   = !reset && (icache2mem_command == BUS_LOAD);
   assign w_i_bad   = !reset && (icache2mem_command == BUS_STORE);
   assign w_starved = (r_starve == STARVE_MAX);

   // Grant selection: a held requester keeps the bus; otherwise dcache first unless icache is starved.
   always_comb begin
      w_gnt_d = 1'b0;
      w_gnt_i = 1'b0;
      if ((r_state == ARB_HOLD_D) && w_d_vld) begin
         w_gnt_d = 1'b1;
      end else if ((r_state == ARB_HOLD_I) && w_i_vld) begin
         w_gnt_i = 1'b1;
      end else if (w_i_vld && w_starved) begin
         w_gnt_i = 1'b1;
      end else if (w_d_vld) begin
         w_gnt_d = 1'b1;
      end else if (w_i_vld) begin
         w_gnt_i = 1'b1;
      end
   end

   assign w_gnt         = w_gnt_d || w_gnt_i;
   assign w_accepted    = w_gnt && (mem2proc_response != '0);
   assign w_alloc_en    = w_accepted && (proc2mem_command == BUS_LOAD);
   assign w_alloc_owner = w_gnt_i ? OWN_ICACHE : OWN_DCACHE;

   // Drive the winner's request onto the memory bus; store data only leaves with a store.
   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (w_gnt_d) begin
         proc2mem_command = dcache2mem_command;
         proc2mem_addr    = dcache2mem_addr;
         if (dcache2mem_command == BUS_STORE) begin
            proc2mem_data = dcache2mem_data;
         end
      end else if (w_gnt_i) begin
         proc2mem_command = BUS_LOAD;
         proc2mem_addr    = icache2mem_addr;
      end
   end

   assign mem2dcache_response = w_gnt_d ? mem2proc_response : '0;
   assign mem2icache_response = w_gnt_i ? mem2proc_response : '0;

   assign w_ret_en = !reset && (mem2proc_tag != '0);

   mem_tag_owner_table u_owner_table (
      .clock         (clock),
      .reset         (reset),
      .i_alloc_en    (w_alloc_en),
      .i_alloc_tag   (mem2proc_response),
      .i_alloc_owner (w_alloc_owner),
      .i_ret_en      (w_ret_en),
      .i_ret_tag     (mem2proc_tag),
      .o_ret_hit     (w_ret_hit),
      .o_ret_owner   (w_ret_owner),
      .i_ext_err     (w_i_bad),
      .o_err         (err_tag)
   );

   assign mem2dcache_tag  = (w_ret_hit && (w_ret_owner == OWN_DCACHE)) ? mem2proc_tag  : '0;
   assign mem2dcache_data = (w_ret_hit && (w_ret_owner == OWN_DCACHE)) ? mem2proc_data : '0;
   assign mem2icache_tag  = (w_ret_hit && (w_ret_owner == OWN_ICACHE)) ? mem2proc_tag  : '0;
   assign mem2icache_data = (w_ret_hit && (w_ret_owner == OWN_ICACHE)) ? mem2proc_data : '0;

   // Arbitration FSM: hold the winner while memory refuses it, else return to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ARB_IDLE;
      end else if (w_gnt && (mem2proc_response == '0)) begin
         r_state <= w_gnt_d ? ARB_HOLD_D : ARB_HOLD_I;
      end else begin
         r_state <= ARB_IDLE;
      end
   end

   // Starvation counter: counts consecutive denied icache cycles, saturating at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (!w_i_vld || w_gnt_i) begin
         r_starve <= '0;
      end else if (!w_starved) begin
         r_starve <= r_starve + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a queued scoreboard and a negedge monitor.
// Each applied vector pushes its hand-computed expected outputs; the monitor pops and compares.
// Inputs change 1 time unit after posedge; outputs are sampled on the following negedge.
module tb_mem_bus_arbiter;
   import sys_defs::*;

   typedef struct packed {
      BUS_COMMAND     pc;
      logic [31:0]    pa;
      logic [63:0]    pd;
      logic [3:0]     dr;
      logic [3:0]     ir;
      logic [3:0]     dt;
      logic [63:0]    ddat;
      logic [3:0]     it;
      logic [63:0]    idat;
      logic           err;
   } exp_t;

   localparam BUS_COMMAND N = BUS_NONE;
   localparam BUS_COMMAND L = BUS_LOAD;
   localparam BUS_COMMAND S = BUS_STORE;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   BUS_COMMAND           dcache2mem_command = BUS_NONE;
   logic [31:0]          dcache2mem_addr = '0;
   logic [DATA_SIZE-1:0] dcache2mem_data = '0;
   logic [TAG_W-1:0]     mem2dcache_response;
   logic [TAG_W-1:0]     mem2dcache_tag;
   logic [DATA_SIZE-1:0] mem2dcache_data;
   BUS_COMMAND           icache2mem_command = BUS_NONE;
   logic [31:0]          icache2mem_addr = '0;
   logic [TAG_W-1:0]     mem2icache_response;
   logic [TAG_W-1:0]     mem2icache_tag;
   logic [DATA_SIZE-1:0] mem2icache_data;
   BUS_COMMAND           proc2mem_command;
   logic [31:0]          proc2mem_addr;
   logic [DATA_SIZE-1:0] proc2mem_data;
   logic [TAG_W-1:0]     mem2proc_response = '0;
   logic [TAG_W-1:0]     mem2proc_tag = '0;
   logic [DATA_SIZE-1:0] mem2proc_data = '0;
   logic                 err_tag;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   bit   drv_done = 1'b0;
   bit   bad;

   mem_bus_arbiter dut (
      .clock               (clock),
      .reset               (reset),
      .dcache2mem_command  (dcache2mem_command),
      .dcache2mem_addr     (dcache2mem_addr),
      .dcache2mem_data     (dcache2mem_data),
      .mem2dcache_response (mem2dcache_response),
      .mem2dcache_tag      (mem2dcache_tag),
      .mem2dcache_data     (mem2dcache_data),
      .icache2mem_command  (icache2mem_command),
      .icache2mem_addr     (icache2mem_addr),
      .mem2icache_response (mem2icache_response),
      .mem2icache_tag      (mem2icache_tag),
      .mem2icache_data     (mem2icache_data),
      .proc2mem_command    (proc2mem_command),
      .proc2mem_addr       (proc2mem_addr),
      .proc2mem_data       (proc2mem_data),
      .mem2proc_response   (mem2proc_response),
      .mem2proc_tag        (mem2proc_tag),
      .mem2proc_data       (mem2proc_data),
      .err_tag             (err_tag)
   );

   always #5 clock = ~clock;

   // Apply one cycle of stimulus and queue the outputs expected for that cycle.
   task automatic v(input logic rst, input BUS_COMMAND dc, input logic [31:0] da, input logic [63:0] dd,
                    input BUS_COMMAND ic, input logic [31:0] ia, input logic [3:0] rsp, input logic [3:0] rt,
                    input logic [63:0] rd, input BUS_COMMAND epc, input logic [31:0] epa, input logic [63:0] epd,
                    input logic [3:0] edr, input logic [3:0] eir, input logic [3:0] edt, input logic [63:0] edd,
                    input logic [3:0] eit, input logic [63:0] eid, input logic eerr);
      exp_t e;
      @(posedge clock);
      #1;
      reset              = rst;
      dcache2mem_command = dc;
      dcache2mem_addr    = da;
      dcache2mem_data    = dd;
      icache2mem_command = ic;
      icache2mem_addr    = ia;
      mem2proc_response  = rsp;
      mem2proc_tag       = rt;
      mem2proc_data      = rd;
      e.pc = epc; e.pa = epa; e.pd = epd; e.dr = edr; e.ir = eir; e.dt = edt;
      e.ddat = edd; e.it = eit; e.idat = eid; e.err = eerr;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         $display("FAIL vec %0d %s: got %h, expected %h", n_vec, nm, act, exp);
         bad = 1'b1;
      end
   endtask

   // Stimulus: directed vectors, expected outputs computed by hand.
   initial begin : driver
      //    rst dc da      dd     ic ia      rsp   rt    rd       | pc pa      pd    dr    ir    dt    ddat     it    idat     err
      v(1, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(1, L, 32'h100, 64'h0,  L, 32'h200, 4'd3, 4'd1, 64'h11,   N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      // dcache load alone, then its data return
      v(0, L, 32'h100, 64'h0,  N, 32'h0,   4'd3, 4'd0, 64'h0,    L, 32'h100, 64'h0, 4'd3, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd3, 64'hDEAD, N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd3, 64'hDEAD, 4'd0, 64'h0,  0);
      // contention: dcache wins four times, icache forced on the fifth
      v(0, L, 32'h110, 64'h0,  L, 32'h210, 4'd5, 4'd0, 64'h0,    L, 32'h110, 64'h0, 4'd5, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h110, 64'h0,  L, 32'h210, 4'd6, 4'd0, 64'h0,    L, 32'h110, 64'h0, 4'd6, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h110, 64'h0,  L, 32'h210, 4'd8, 4'd0, 64'h0,    L, 32'h110, 64'h0, 4'd8, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h110, 64'h0,  L, 32'h210, 4'd9, 4'd0, 64'h0,    L, 32'h110, 64'h0, 4'd9, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h110, 64'h0,  L, 32'h210, 4'd10, 4'd0, 64'h0,   L, 32'h210, 64'h0, 4'd0, 4'd10, 4'd0, 64'h0,  4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd10, 64'hAAAA, N, 32'h0,  64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd10, 64'hAAAA, 0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd5, 64'h5555, N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd5, 64'h5555, 4'd0, 64'h0,  0);
      // icache held through two busy cycles despite a dcache request
      v(0, N, 32'h0,   64'h0,  L, 32'h200, 4'd0, 4'd0, 64'h0,    L, 32'h200, 64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h120, 64'h0,  L, 32'h200, 4'd0, 4'd0, 64'h0,    L, 32'h200, 64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h120, 64'h0,  L, 32'h200, 4'd7, 4'd0, 64'h0,    L, 32'h200, 64'h0, 4'd0, 4'd7, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h120, 64'h0,  N, 32'h0,   4'd11, 4'd0, 64'h0,   L, 32'h120, 64'h0, 4'd11, 4'd0, 4'd0, 64'h0,  4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd7, 64'h77,   N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd7, 64'h77,  0);
      // same-cycle return of tag 4 to icache and re-allocation of tag 4 to dcache
      v(0, N, 32'h0,   64'h0,  L, 32'h240, 4'd4, 4'd0, 64'h0,    L, 32'h240, 64'h0, 4'd0, 4'd4, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h140, 64'h0,  N, 32'h0,   4'd4, 4'd4, 64'hBEEF, L, 32'h140, 64'h0, 4'd4, 4'd0, 4'd0, 64'h0,   4'd4, 64'hBEEF, 0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd4, 64'hCAFE, N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd4, 64'hCAFE, 4'd0, 64'h0,  0);
      // store allocates nothing; its tag coming back is dropped and flagged
      v(0, S, 32'h300, 64'h55, N, 32'h0,   4'd2, 4'd0, 64'h0,    S, 32'h300, 64'h55, 4'd2, 4'd0, 4'd0, 64'h0,  4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd2, 64'h1234, N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   1);
      // reset with tags 6, 8, 9, 11 outstanding; a later return of 6 is dropped
      v(1, L, 32'h180, 64'h0,  L, 32'h280, 4'd1, 4'd6, 64'h66,   N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd6, 64'h66,   N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   1);
      // allocation over a live tag: overwritten and flagged
      v(1, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, L, 32'h400, 64'h0,  N, 32'h0,   4'd12, 4'd0, 64'h0,   L, 32'h400, 64'h0, 4'd12, 4'd0, 4'd0, 64'h0,  4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  L, 32'h410, 4'd12, 4'd0, 64'h0,   L, 32'h410, 64'h0, 4'd0, 4'd12, 4'd0, 64'h0,  4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd12, 64'h99,  N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd12, 64'h99, 1);
      // icache store is ignored and flagged
      v(1, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  S, 32'h500, 4'd3, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   0);
      v(0, N, 32'h0,   64'h0,  N, 32'h0,   4'd0, 4'd0, 64'h0,    N, 32'h0,   64'h0, 4'd0, 4'd0, 4'd0, 64'h0,   4'd0, 64'h0,   1);
      drv_done = 1'b1;
   end

   // Monitor: pop one expected record per presented cycle and compare every output.
   initial begin : monitor
      exp_t e;
      int   idle;
      idle = 0;
      while (!(drv_done && sb_q.size() == 0) && idle < 200) begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bad = 1'b0;
            chk("proc2mem_command",    64'(proc2mem_command),    64'(e.pc));
            chk("proc2mem_addr",       64'(proc2mem_addr),       64'(e.pa));
            chk("proc2mem_data",       proc2mem_data,            e.pd);
            chk("mem2dcache_response", 64'(mem2dcache_response), 64'(e.dr));
            chk("mem2icache_response", 64'(mem2icache_response), 64'(e.ir));
            chk("mem2dcache_tag",      64'(mem2dcache_tag),      64'(e.dt));
            chk("mem2dcache_data",     mem2dcache_data,          e.ddat);
            chk("mem2icache_tag",      64'(mem2icache_tag),      64'(e.it));
            chk("mem2icache_data",     mem2icache_data,          e.idat);
            chk("err_tag",             64'(err_tag),             64'(e.err));
            n_vec++;
            if (bad) n_miss++;
            idle = 0;
         end else begin
            idle++;
         end
      end
      if (!drv_done || sb_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d vectors left, driver done %0d, expected 0 left and done 1", sb_q.size(), drv_done);
         n_miss++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
